// File: rtl/arb_dds_bank_loader.sv
// Ping-pong bank write controller for the DDS output selector: fills the idle bank, swaps SEL at the next wrap.
// Optional build macro ARB_LOADER_LEN_EN adds the Wave_len output (committed sample count).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no load in progress, counter at 0, ready for first sample
// LOAD      | writing samples into the inactive bank
// FULL      | inactive bank completely written, waiting for Commit
// SWAP_WAIT | committed, waiting for the next playback Wrap to toggle SEL
module arb_dds_bank_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Din,
    input  logic              Din_valid,
    output logic              Din_ready,
    input  logic              Commit,
    input  logic              Wrap,
    output logic              Wr_en0,
    output logic              Wr_en1,
    output logic [ADDR_W-1:0] Wr_addr,
    output logic [DATA_W-1:0] Wr_data,
    output logic              SEL,
    output logic              Busy,
`ifdef ARB_LOADER_LEN_EN
    output logic [ADDR_W:0]   Wave_len,
`endif
    output logic              Load_done
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_FULL      = 2'd2,
        S_SWAP_WAIT = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] FULL_LEN  = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              sel_q, sel_d;
    logic              load_done_q, load_done_d;
    logic              wr_en0_q, wr_en0_d;
    logic              wr_en1_q, wr_en1_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W:0]   wave_len_q, wave_len_d;

    logic accept;
    logic swap;

    // Ready is forced low while Reset is held so no sample is taken during reset.
    assign accept = Din_valid && Din_ready;
    assign swap   = (state_q == S_SWAP_WAIT) && Wrap;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            load_done_q <= 1'b0;
            wr_en0_q    <= 1'b0;
            wr_en1_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wave_len_q  <= FULL_LEN;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            load_done_q <= load_done_d;
            wr_en0_q    <= wr_en0_d;
            wr_en1_q    <= wr_en1_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wave_len_q  <= wave_len_d;
        end
    end

    // Commit in the same cycle as the last accept wins over the FULL transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (Commit)                             state_d = S_SWAP_WAIT;
                else if (accept && (cnt_q == LAST_ADDR)) state_d = S_FULL;
            end
            S_FULL: begin
                if (Commit) state_d = S_SWAP_WAIT;
            end
            S_SWAP_WAIT: begin
                if (Wrap) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (swap)        cnt_d = '0;
        else if (accept) cnt_d = cnt_q + 1'b1;

        wr_en0_d    = accept && !sel_q;
        wr_en1_d    = accept && sel_q;
        wr_addr_d   = accept ? cnt_q[ADDR_W-1:0] : wr_addr_q;
        wr_data_d   = accept ? Din : wr_data_q;
        sel_d       = swap ? ~sel_q : sel_q;
        load_done_d = swap;
        wave_len_d  = swap ? cnt_q : wave_len_q;
    end

    always_comb begin
        Din_ready = !Reset && ((state_q == S_IDLE) || (state_q == S_LOAD));
        Busy      = (state_q != S_IDLE);
        Wr_en0    = wr_en0_q;
        Wr_en1    = wr_en1_q;
        Wr_addr   = wr_addr_q;
        Wr_data   = wr_data_q;
        SEL       = sel_q;
        Load_done = load_done_q;
    end

`ifdef ARB_LOADER_LEN_EN
    assign Wave_len = wave_len_q;
`else
    logic unused_wave_len;
    assign unused_wave_len = ^wave_len_q;
`endif

endmodule

// File: tb/tb_arb_dds_bank_loader.sv
// Directed bench for arb_dds_bank_loader at ADDR_W=4 (16-deep banks).
module tb_arb_dds_bank_loader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic              Clock = 1'b0;
    logic              Reset;
    logic [DATA_W-1:0] Din;
    logic              Din_valid;
    logic              Din_ready;
    logic              Commit;
    logic              Wrap;
    logic              Wr_en0;
    logic              Wr_en1;
    logic [ADDR_W-1:0] Wr_addr;
    logic [DATA_W-1:0] Wr_data;
    logic              SEL;
    logic              Busy;
    logic              Load_done;
`ifdef ARB_LOADER_LEN_EN
    logic [ADDR_W:0]   Wave_len;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    arb_dds_bank_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Din       (Din),
        .Din_valid (Din_valid),
        .Din_ready (Din_ready),
        .Commit    (Commit),
        .Wrap      (Wrap),
        .Wr_en0    (Wr_en0),
        .Wr_en1    (Wr_en1),
        .Wr_addr   (Wr_addr),
        .Wr_data   (Wr_data),
        .SEL       (SEL),
        .Busy      (Busy),
`ifdef ARB_LOADER_LEN_EN
        .Wave_len  (Wave_len),
`endif
        .Load_done (Load_done)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic e0, input logic e1,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        chk({tag, " wr_en0"}, 32'(Wr_en0), 32'(e0));
        chk({tag, " wr_en1"}, 32'(Wr_en1), 32'(e1));
        chk({tag, " wr_addr"}, 32'(Wr_addr), 32'(a));
        chk({tag, " wr_data"}, 32'(Wr_data), 32'(d));
    endtask

    initial begin
        Reset = 1'b1; Din = '0; Din_valid = 1'b0; Commit = 1'b0; Wrap = 1'b0;
        tick(); tick();
        chk("rst din_ready", 32'(Din_ready), 0);
        chk("rst sel", 32'(SEL), 0);
        chk("rst busy", 32'(Busy), 0);
        chk("rst load_done", 32'(Load_done), 0);
        chk_wr("rst", 1'b0, 1'b0, 4'd0, 16'h0000);
`ifdef ARB_LOADER_LEN_EN
        chk("rst wave_len", 32'(Wave_len), 16);
`endif
        Reset = 1'b0;
        #1;
        chk("post-rst din_ready", 32'(Din_ready), 1);

        // Full load of bank0
        for (int i = 0; i < 16; i++) begin
            Din = 16'h0100 + 16'(i); Din_valid = 1'b1;
            tick();
            chk_wr("load0", 1'b1, 1'b0, 4'(i), 16'h0100 + 16'(i));
            chk("load0 busy", 32'(Busy), 1);
        end
        chk("full din_ready", 32'(Din_ready), 0);
        Din = 16'hDEAD;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("full stall wr_en0", 32'(Wr_en0), 0);
            chk("full stall wr_en1", 32'(Wr_en1), 0);
            chk("full stall ready", 32'(Din_ready), 0);
        end
        Commit = 1'b1;
        tick();
        Commit = 1'b0;
        chk("swap_wait busy", 32'(Busy), 1);
        chk("swap_wait sel", 32'(SEL), 0);
        chk("swap_wait ready", 32'(Din_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("swap_wait stall wr_en0", 32'(Wr_en0), 0);
            chk("swap_wait load_done", 32'(Load_done), 0);
        end
        Wrap = 1'b1;
        tick();
        Wrap = 1'b0; Din_valid = 1'b0;
        chk("swap1 sel", 32'(SEL), 1);
        chk("swap1 load_done", 32'(Load_done), 1);
        chk("swap1 busy", 32'(Busy), 0);
        chk("swap1 ready", 32'(Din_ready), 1);
`ifdef ARB_LOADER_LEN_EN
        chk("swap1 wave_len", 32'(Wave_len), 16);
`endif
        tick();
        chk("swap1 load_done drop", 32'(Load_done), 0);
        chk("swap1 sel hold", 32'(SEL), 1);

        // Partial load of bank1; commit in the same cycle as the third sample
        for (int i = 0; i < 3; i++) begin
            Din = 16'h0A00 + 16'(i); Din_valid = 1'b1; Commit = (i == 2);
            tick();
            chk_wr("load1", 1'b0, 1'b1, 4'(i), 16'h0A00 + 16'(i));
        end
        Din_valid = 1'b0; Commit = 1'b0;
        chk("load1 swap_wait ready", 32'(Din_ready), 0);
        chk("load1 swap_wait busy", 32'(Busy), 1);
        tick();
        chk("load1 strobe drop", 32'(Wr_en1), 0);
        Wrap = 1'b1;
        tick();
        Wrap = 1'b0;
        chk("swap2 sel", 32'(SEL), 0);
        chk("swap2 load_done", 32'(Load_done), 1);
`ifdef ARB_LOADER_LEN_EN
        chk("swap2 wave_len", 32'(Wave_len), 3);
`endif

        // Wrap in IDLE is ignored
        Wrap = 1'b1;
        tick();
        Wrap = 1'b0;
        chk("idle wrap sel", 32'(SEL), 0);
        chk("idle wrap load_done", 32'(Load_done), 0);

        // Commit coincident with Wrap: that Wrap does not count
        for (int i = 0; i < 2; i++) begin
            Din = 16'h0B00 + 16'(i); Din_valid = 1'b1;
            tick();
            chk_wr("load3", 1'b1, 1'b0, 4'(i), 16'h0B00 + 16'(i));
        end
        Din_valid = 1'b0;
        Commit = 1'b1; Wrap = 1'b1;
        tick();
        Commit = 1'b0; Wrap = 1'b0;
        chk("coinc sel", 32'(SEL), 0);
        chk("coinc busy", 32'(Busy), 1);
        chk("coinc load_done", 32'(Load_done), 0);
        for (int i = 0; i < 19; i++) tick();
        chk("coinc wait sel", 32'(SEL), 0);
        Wrap = 1'b1;
        tick();
        Wrap = 1'b0;
        chk("swap3 sel", 32'(SEL), 1);
        chk("swap3 load_done", 32'(Load_done), 1);
`ifdef ARB_LOADER_LEN_EN
        chk("swap3 wave_len", 32'(Wave_len), 2);
`endif

        // Commit in IDLE with no data is ignored
        tick();
        Commit = 1'b1;
        tick();
        Commit = 1'b0;
        chk("idle commit busy", 32'(Busy), 0);
        chk("idle commit ready", 32'(Din_ready), 1);
        Wrap = 1'b1;
        tick();
        Wrap = 1'b0;
        chk("idle commit sel", 32'(SEL), 1);
        chk("idle commit load_done", 32'(Load_done), 0);

        // Reset mid-load
        for (int i = 0; i < 7; i++) begin
            Din = 16'h0C00 + 16'(i); Din_valid = 1'b1;
            tick();
            chk_wr("load4", 1'b0, 1'b1, 4'(i), 16'h0C00 + 16'(i));
        end
        Din_valid = 1'b0;
        Reset = 1'b1;
        tick();
        chk("midrst ready", 32'(Din_ready), 0);
        Reset = 1'b0;
        #1;
        chk("midrst sel", 32'(SEL), 0);
        chk("midrst busy", 32'(Busy), 0);
        chk("midrst ready after", 32'(Din_ready), 1);
        chk_wr("midrst", 1'b0, 1'b0, 4'd0, 16'h0000);
        Din = 16'h0D00; Din_valid = 1'b1;
        tick();
        Din_valid = 1'b0;
        chk_wr("post-midrst", 1'b1, 1'b0, 4'd0, 16'h0D00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
